boundary_scan_chain: RTL

- Parametrised boundary-scan register chain of `WIDTH` cells, each with capture, shift and update stages.
- Contains its own sequencing FSM: one `start` pulse runs a complete capture/shift/update operation with no further control.
- The update stage holds pin drive stable during shifting; per-cell observe-only cells never override the pin.
- Sits between a core's ports and the pads, daisy-chained with other chains and with internal scan through `sin`/`sout`.

---
 rtl/boundary_scan_chain.sv | 102 ++++++++++
 1 files changed

// File: rtl/boundary_scan_chain.sv
// Boundary-scan register chain with capture/shift/update stages and a built-in
// sequencer: a single start pulse runs one complete scan operation.
module boundary_scan_chain #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] OBSERVE_MASK = {WIDTH{1'b0}},
    parameter int               CW           = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             testing,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sin,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    shift_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SHIFT   = 2'd2,
        S_UPDATE  = 2'd3
    } state_t;

    localparam logic [1:0]    OP_FULL         = 2'b00;
    localparam logic [1:0]    OP_SHIFT_UPDATE = 2'b01;
    localparam logic [1:0]    OP_CAPTURE      = 2'b10;
    localparam logic [CW-1:0] LAST_SHIFT      = CW'(WIDTH - 1);

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] update_reg;

    // Handshake: start is only looked at in IDLE; busy covers every non-IDLE
    // cycle and done pulses for one cycle once busy has already dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            op_q        <= OP_FULL;
            shift_reg   <= '0;
            update_reg  <= '0;
            shift_count <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        shift_count <= '0;
                        if (op == OP_FULL || op == OP_CAPTURE)
                            state <= S_CAPTURE;
                        else if (op == OP_SHIFT_UPDATE)
                            state <= S_SHIFT;
                        else
                            state <= S_UPDATE;
                    end
                end
                S_CAPTURE: begin
                    shift_reg <= pin_in;
                    if (op_q == OP_FULL) begin
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    // MSB leaves first on sout; the first bit in lands in the MSB.
                    shift_reg   <= {shift_reg[WIDTH-2:0], sin};
                    shift_count <= shift_count + 1'b1;
                    if (shift_count == LAST_SHIFT)
                        state <= S_UPDATE;
                end
                S_UPDATE: begin
                    update_reg <= shift_reg;
                    state      <= S_IDLE;
                    done       <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign sout      = shift_reg[WIDTH-1];
    assign state_dbg = state;

    // Observe-only cells always pass the functional value through.
    always_comb begin
        pin_out = pin_in;
        if (testing)
            pin_out = (update_reg & ~OBSERVE_MASK) | (pin_in & OBSERVE_MASK);
    end

endmodule
